// File: rtl/uart_cmd_controller.sv
// uart_cmd_controller: sequences a two-byte UART command (command, address)
// into a valid/ready sensor request, waits for the sensor response and sends
// a two-byte reply (code, data) through the transmitter. All protocol
// timeouts and error replies are generated here.
// Optional feature: define UART_CMD_OVERRUN_EN to add the overrun flag that
// records bytes dropped while busy and marks the next reply code (bit 7).
module uart_cmd_controller #(
  parameter int         BYTE_TIMEOUT = 2_500_000,
  parameter int         RESP_TIMEOUT = 50_000_000,
  parameter int         ADDR_BITS    = 5,
  parameter logic [7:0] ERR_ADDR     = 8'hE1,
  parameter logic [7:0] ERR_RESP     = 8'hE2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_done,
  input  logic [7:0]           rx_data,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_code,
  output logic [ADDR_BITS-1:0] cmd_addr,
  input  logic                 cmd_ready,
  input  logic                 resp_valid,
  input  logic [7:0]           resp_code,
  input  logic [7:0]           resp_data,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy
`ifdef UART_CMD_OVERRUN_EN
  ,
  output logic                 overrun
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ADDR = 3'd1,
    ISSUE     = 3'd2,
    WAIT_RESP = 3'd3,
    TX0       = 3'd4,
    TX1       = 3'd5
  } state_t;

  // Timer compares are done against the last cycle of each window.
  localparam logic [25:0] BYTE_LAST = 26'(BYTE_TIMEOUT - 1);
  localparam logic [25:0] RESP_LAST = 26'(RESP_TIMEOUT - 1);
  localparam logic [25:0] TIMER_MAX = 26'h3FF_FFFF;

  state_t                 state;
  state_t                 state_next;
  logic [25:0]            timer;
  logic [25:0]            timer_next;
  logic                   rx_done_d;
  logic                   strobe;
  logic                   addr_ok;
  logic                   entering;
  logic                   clear_all;
  logic [7:0]             cmd_code_next;
  logic [ADDR_BITS-1:0]   cmd_addr_next;
  logic [7:0]             code_hold;
  logic [7:0]             data_hold;
  logic [7:0]             code_next;
  logic [7:0]             data_next;
  logic [7:0]             tx_code;
  logic                   cmd_valid_next;
  logic                   tx_start_next;
  logic [7:0]             tx_data_next;
  logic                   busy_next;

  // One strobe per received byte, however long rx_done stays high.
  assign strobe  = rx_done & ~rx_done_d;
  // Address is in range when no bit above the address field is set.
  assign addr_ok = ((rx_data >> ADDR_BITS) == 8'd0);

  // Next-state and datapath-latch decisions for the command sequencer.
  always_comb begin
    state_next    = state;
    cmd_code_next = cmd_code;
    cmd_addr_next = cmd_addr;
    code_next     = code_hold;
    data_next     = data_hold;
    clear_all     = 1'b0;
    case (state)
      IDLE: begin
        if (strobe) begin
          cmd_code_next = rx_data;
          state_next    = WAIT_ADDR;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_ADDR: begin
        if (strobe) begin
          if (addr_ok) begin
            cmd_addr_next = rx_data[ADDR_BITS-1:0];
            state_next    = ISSUE;
          end else begin
            code_next  = ERR_ADDR;
            data_next  = rx_data;
            state_next = TX0;
          end
        end else if (timer == BYTE_LAST) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_ADDR;
        end
      end
      ISSUE: begin
        if (cmd_valid && cmd_ready) begin
          state_next = WAIT_RESP;
        end else begin
          state_next = ISSUE;
        end
      end
      WAIT_RESP: begin
        if (resp_valid) begin
          code_next  = resp_code;
          data_next  = resp_data;
          state_next = TX0;
        end else if (timer == RESP_LAST) begin
          code_next  = ERR_RESP;
          data_next  = cmd_code;
          state_next = TX0;
        end else begin
          state_next = WAIT_RESP;
        end
      end
      TX0: begin
        if (tx_done) begin
          state_next = TX1;
        end else begin
          state_next = TX0;
        end
      end
      TX1: begin
        if (tx_done) begin
          state_next = IDLE;
        end else begin
          state_next = TX1;
        end
      end
      default: begin
        state_next    = IDLE;
        cmd_code_next = 8'h00;
        cmd_addr_next = {ADDR_BITS{1'b0}};
        code_next     = 8'h00;
        data_next     = 8'h00;
        clear_all     = 1'b1;
      end
    endcase
  end

`ifdef UART_CMD_OVERRUN_EN
  logic overrun_next;

  // Overrun sets on any byte dropped while busy and clears on the next accepted command byte.
  always_comb begin
    overrun_next = overrun;
    if (clear_all) begin
      overrun_next = 1'b0;
    end else if (strobe && busy) begin
      overrun_next = 1'b1;
    end else if (strobe && (state == IDLE)) begin
      overrun_next = 1'b0;
    end else begin
      overrun_next = overrun;
    end
    tx_code = {code_next[7] | overrun_next, code_next[6:0]};
  end

  // Overrun flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun_next;
    end
  end
`else
  assign tx_code = code_next;
`endif

  // Registered-output values derived from the upcoming state.
  always_comb begin
    entering       = (state_next != state);
    cmd_valid_next = (state_next == ISSUE);
    busy_next      = (state_next != IDLE) && (state_next != WAIT_ADDR);
    tx_start_next  = entering && ((state_next == TX0) || (state_next == TX1));
    tx_data_next   = tx_data;
    timer_next     = timer;
    if (clear_all) begin
      tx_data_next = 8'h00;
    end else if (entering && (state_next == TX0)) begin
      tx_data_next = tx_code;
    end else if (entering && (state_next == TX1)) begin
      tx_data_next = data_next;
    end else begin
      tx_data_next = tx_data;
    end
    if (clear_all || entering) begin
      timer_next = 26'd0;
    end else if (timer == TIMER_MAX) begin
      timer_next = timer;
    end else begin
      timer_next = timer + 26'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath, timer and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer     <= 26'd0;
      rx_done_d <= 1'b0;
      cmd_code  <= 8'h00;
      cmd_addr  <= {ADDR_BITS{1'b0}};
      code_hold <= 8'h00;
      data_hold <= 8'h00;
      cmd_valid <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
    end else begin
      timer     <= timer_next;
      rx_done_d <= rx_done;
      cmd_code  <= cmd_code_next;
      cmd_addr  <= cmd_addr_next;
      code_hold <= code_next;
      data_hold <= data_next;
      cmd_valid <= cmd_valid_next;
      tx_start  <= tx_start_next;
      tx_data   <= tx_data_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Self-checking bench for uart_cmd_controller (BYTE_TIMEOUT=1000,
// RESP_TIMEOUT=2000, ADDR_BITS=5). A sensor/transmitter model reacts to the
// DUT; each transaction's outcome is predicted from the protocol rules.
module tb_uart_cmd_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [4:0] cmd_addr;
  logic       cmd_ready = 1'b0;
  logic       resp_valid = 1'b0;
  logic [7:0] resp_code = 8'h00;
  logic [7:0] resp_data = 8'h00;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic       busy;
`ifdef UART_CMD_OVERRUN_EN
  logic       overrun;
`endif

  uart_cmd_controller #(
    .BYTE_TIMEOUT(1000),
    .RESP_TIMEOUT(2000),
    .ADDR_BITS(5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_done(rx_done), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_addr(cmd_addr),
    .cmd_ready(cmd_ready), .resp_valid(resp_valid), .resp_code(resp_code),
    .resp_data(resp_data), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy)
`ifdef UART_CMD_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment configuration, written by the stimulus
  int         cfg_stall = 0;
  int         cfg_rk = 0;
  int         cfg_lat = 4;
  logic [7:0] cfg_rc = 8'h00;
  logic [7:0] cfg_rd = 8'h00;

  // Environment observations, written by the responder
  int         vtotal = 0;
  int         vrun = 0;
  int         xfer_n = 0;
  int         x_cyc = 0;
  logic [7:0] x_code = 8'h00;
  logic [4:0] x_addr = 5'd0;
  int         resp_at = -1;
  int         done_at = -1;
  int         unstable = 0;
  logic       in_tx = 1'b0;
  logic [7:0] hold = 8'h00;
  logic [7:0] txq[$];
  int         tsq[$];

  int vectors = 0;
  int miscompares = 0;

  // Sensor and transmitter responder; inputs change on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      cmd_ready = 1'b0; resp_valid = 1'b0; tx_done = 1'b0;
      vrun = 0; resp_at = -1; done_at = -1; in_tx = 1'b0;
    end else begin
      if (cmd_valid) begin
        vrun++; vtotal++;
        cmd_ready = (vrun > cfg_stall);
      end else begin
        vrun = 0; cmd_ready = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        xfer_n++; x_code = cmd_code; x_addr = cmd_addr; x_cyc = cyc;
        resp_at = (cfg_rk > 0) ? cyc + cfg_rk : -1;
      end
      if (resp_valid) resp_valid = 1'b0;
      if (cyc == resp_at) begin
        resp_valid = 1'b1; resp_code = cfg_rc; resp_data = cfg_rd; resp_at = -1;
      end
      if (tx_done) tx_done = 1'b0;
      if (tx_start) begin
        txq.push_back(tx_data); tsq.push_back(cyc);
        done_at = cyc + cfg_lat; hold = tx_data; in_tx = 1'b1;
      end else if (in_tx && (tx_data !== hold)) begin
        unstable++;
      end
      if (cyc == done_at) begin
        tx_done = 1'b1; done_at = -1; in_tx = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one command, straight from the protocol rules.
  function automatic void model(input logic [7:0] c, input logic [7:0] a, input int rk,
                                input logic [7:0] rc, input logic [7:0] rd,
                                output logic x, output logic [7:0] b0, output logic [7:0] b1,
                                output int rl);
    if (a >= 8'd32) begin
      x = 1'b0; b0 = 8'hE1; b1 = a; rl = 0;
    end else if (rk >= 1 && rk <= 2000) begin
      x = 1'b1; b0 = rc; b1 = rd; rl = rk;
    end else begin
      x = 1'b1; b0 = 8'hE2; b1 = c; rl = 2000;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int w, output int c0);
    @(negedge clk);
    rx_data = b; rx_done = 1'b1; c0 = cyc;
    repeat (w) @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit, input string tag);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      @(negedge clk); #1;
      n++;
      ok = (txq.size() >= base + 2) && !busy;
    end
    check({tag, "_complete"}, ok, 1);
  endtask

  task automatic run_txn(input string tag, input logic [7:0] c, input logic [7:0] a,
                         input int stall, input int rk, input logic [7:0] rc,
                         input logic [7:0] rd, input int w, input int gap, input int lat);
    logic ex;
    logic [7:0] e0, e1;
    int rl, tb, xb, vb, ub, cc, ca, s0;
    model(c, a, rk, rc, rd, ex, e0, e1, rl);
    cfg_stall = stall; cfg_rk = rk; cfg_rc = rc; cfg_rd = rd; cfg_lat = lat;
    tb = txq.size(); xb = xfer_n; vb = vtotal; ub = unstable;
    send_byte(c, w, cc);
    repeat (gap) @(negedge clk);
    send_byte(a, w, ca);
    wait_done(tb, 4000, tag);
    check({tag, "_xfer"}, xfer_n - xb, {31'd0, ex});
    if (ex) begin
      check({tag, "_code"}, x_code, c);
      check({tag, "_addr"}, x_addr, a[4:0]);
      check({tag, "_vcyc"}, vtotal - vb, stall + 1);
      s0 = x_cyc + rl + 1;
    end else begin
      check({tag, "_novalid"}, vtotal - vb, 0);
      s0 = ca + 1;
    end
    check({tag, "_txn"}, txq.size() - tb, 2);
    check({tag, "_tx0"}, txq[tb], e0);
    check({tag, "_tx1"}, txq[tb+1], e1);
    check({tag, "_t0"}, tsq[tb], s0);
    check({tag, "_t1"}, tsq[tb+1], s0 + lat + 1);
    check({tag, "_stable"}, unstable - ub, 0);
  endtask

  initial begin
    int cc, ca, tb, tb2, xb, n;
    logic [7:0] c, a, e_code;
    int stall, rk, sel;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_code", cmd_code, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
`ifdef UART_CMD_OVERRUN_EN
    check("rst_overrun", overrun, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // Directed transactions
    run_txn("nominal", 8'h03, 8'h0A, 0, 100, 8'h10, 8'h2C, 50, 5, 6);
    run_txn("oor", 8'h03, 8'h25, 0, 100, 8'h10, 8'h2C, 50, 5, 6);
    run_txn("addr_max", 8'h5A, 8'h1F, 2, 7, 8'h44, 8'h55, 3, 0, 2);
    run_txn("addr_over", 8'h5A, 8'h20, 0, 7, 8'h44, 8'h55, 3, 0, 2);
    run_txn("resp_to", 8'h03, 8'h0A, 30, 0, 8'h10, 8'h2C, 50, 5, 6);
    run_txn("coincide", 8'h03, 8'h0A, 0, 2000, 8'h10, 8'h2C, 10, 2, 3);
    run_txn("late_resp", 8'h03, 8'h0A, 0, 2001, 8'h10, 8'h2C, 10, 2, 3);

    // Inter-byte timeout drops the command; next byte starts a new one
    cfg_stall = 0; cfg_rk = 20; cfg_rc = 8'h31; cfg_rd = 8'h32; cfg_lat = 3;
    tb = txq.size(); xb = xfer_n;
    send_byte(8'h03, 50, cc);
    repeat (1000) @(negedge clk);
    #1;
    check("ibto_busy", busy, 0);
    check("ibto_noxfer", xfer_n - xb, 0);
    check("ibto_notx", txq.size() - tb, 0);
    send_byte(8'h0A, 50, cc);
    send_byte(8'h05, 50, ca);
    wait_done(tb, 4000, "ibto");
    check("ibto_xfer", xfer_n - xb, 1);
    check("ibto_newcmd", x_code, 8'h0A);
    check("ibto_addr", x_addr, 5'h05);
    check("ibto_tx0", txq[tb], 8'h31);

    // Address strobe on the timeout cycle wins
    tb = txq.size(); xb = xfer_n;
    send_byte(8'h03, 20, cc);
    do @(negedge clk); while (cyc < cc + 999);
    send_byte(8'h0B, 20, ca);
    wait_done(tb, 4000, "bwin");
    check("bwin_xfer", xfer_n - xb, 1);
    check("bwin_code", x_code, 8'h03);
    check("bwin_addr", x_addr, 5'h0B);

    // Reset during TX0 aborts with no partial transmission
    cfg_stall = 0; cfg_rk = 10; cfg_rc = 8'h10; cfg_rd = 8'h2C; cfg_lat = 40;
    send_byte(8'h03, 10, cc);
    send_byte(8'h0A, 10, ca);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!tx_start && n < 500);
    check("rst_reach_tx0", tx_start, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_tx_start", tx_start, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_tx_data", tx_data, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    tb2 = txq.size();
    repeat (100) @(negedge clk);
    #1;
    check("rst_no_partial", txq.size() - tb2, 0);
    check("rst_idle_busy", busy, 0);
    run_txn("after_rst", 8'h03, 8'h0A, 0, 100, 8'h10, 8'h2C, 50, 5, 6);

    // Byte arriving while busy is discarded (marks reply when overrun enabled)
    cfg_stall = 0; cfg_rk = 200; cfg_rc = 8'h10; cfg_rd = 8'h2C; cfg_lat = 5;
    tb = txq.size(); xb = xfer_n;
    send_byte(8'h03, 10, cc);
    send_byte(8'h0A, 10, ca);
    repeat (20) @(negedge clk);
    send_byte(8'h77, 10, cc);
    #1;
`ifdef UART_CMD_OVERRUN_EN
    e_code = 8'h90;
    check("ovr_set", overrun, 1);
`else
    e_code = 8'h10;
`endif
    wait_done(tb, 4000, "ovr");
    check("ovr_xfer", xfer_n - xb, 1);
    check("ovr_tx0", txq[tb], e_code);
    check("ovr_tx1", txq[tb+1], 8'h2C);
    tb = txq.size(); xb = xfer_n;
    send_byte(8'h05, 10, cc);
    #1;
`ifdef UART_CMD_OVERRUN_EN
    check("ovr_clear", overrun, 0);
`endif
    send_byte(8'h01, 10, ca);
    wait_done(tb, 4000, "ovr_next");
    check("ovr_next_code", x_code, 8'h05);
    check("ovr_next_tx0", txq[tb], 8'h10);

    // Randomized transactions
    for (int k = 0; k < 24; k++) begin
      c = 8'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 3));
      a = (sel == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      stall = int'($urandom_range(0, 6));
      sel = int'($urandom_range(0, 7));
      rk = (sel == 0) ? 0 : int'($urandom_range(1, 400));
      run_txn("rnd", c, a, stall, rk, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              int'($urandom_range(1, 60)), int'($urandom_range(0, 10)), int'($urandom_range(1, 20)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
